spi_cmd_master: RTL and testbench

- Upstream stage for the SPI slave + single-port RAM top: converts 10-bit command words from a parallel host interface into SS_n/MOSI frames.
- For read-data commands, it captures the 8-bit reply on MISO and returns it to the host.
- Shares the slave's system clock, so all SPI signals are synchronous to clk.
- Command word = {op[1:0], payload[7:0]}; op 00 write-address, 01 write-data, 10 read-address, 11 read-data.

---
 rtl/spi_cmd_master.sv | 99 +++++++++
 tb/tb_spi_cmd_master.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: turns 10-bit host command words into SS_n/MOSI frames and
// captures an 8-bit MISO reply for read-data commands.
module spi_cmd_master #(
    parameter int SETUP_CYC = 2,
    parameter int TURN_CYC  = 2,
    parameter int GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_data,
    output logic       cmd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);
    localparam int M1 = SETUP_CYC > TURN_CYC ? SETUP_CYC : TURN_CYC;
    localparam int M2 = M1 > GAP_CYC ? M1 : GAP_CYC;
    localparam int M3 = M2 > 10 ? M2 : 10;
    localparam int CW = $clog2(M3 + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TURN, CAPTURE, GAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [9:0]    sr;
    logic [7:0]    rx;
    logic          rd_op;

    // busy is the registered "not IDLE" flag, so ready is its complement held low in reset
    assign cmd_ready = ~busy & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sr       <= '0;
            rx       <= '0;
            rd_op    <= 1'b0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    sr    <= cmd_data;
                    rd_op <= &cmd_data[9:8];
                    SS_n  <= 1'b0;
                    MOSI  <= cmd_data[9];
                    busy  <= 1'b1;
                    cnt   <= '0;
                    state <= SETUP;
                end
                SETUP: if (cnt == CW'(SETUP_CYC - 1)) begin
                    cnt   <= '0;
                    MOSI  <= sr[9];
                    sr    <= {sr[8:0], 1'b0};
                    state <= SHIFT;
                end else cnt <= cnt + 1'b1;
                SHIFT: if (cnt == CW'(9)) begin
                    cnt  <= '0;
                    MOSI <= 1'b0;
                    SS_n <= ~rd_op;
                    state <= !rd_op ? GAP : (TURN_CYC == 0 ? CAPTURE : TURN);
                end else begin
                    cnt  <= cnt + 1'b1;
                    MOSI <= sr[9];
                    sr   <= {sr[8:0], 1'b0};
                end
                TURN: if (cnt == CW'(TURN_CYC - 1)) begin
                    cnt   <= '0;
                    state <= CAPTURE;
                end else cnt <= cnt + 1'b1;
                CAPTURE: begin
                    rx <= {rx[6:0], MISO};
                    if (cnt == CW'(7)) begin
                        rd_data  <= {rx[6:0], MISO};
                        rd_valid <= 1'b1;
                        SS_n     <= 1'b1;
                        cnt      <= '0;
                        state    <= GAP;
                    end else cnt <= cnt + 1'b1;
                end
                GAP: if (cnt == CW'(GAP_CYC - 1)) begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: randomized frames checked cycle by cycle against a
// waveform model derived from the frame layout rules.
module tb_spi_cmd_master;
    localparam int SU = 2;
    localparam int TU = 2;
    localparam int GP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_data = '0;
    logic       MISO = 1'b0;
    logic       cmd_ready, rd_valid, busy, SS_n, MOSI;
    logic [7:0] rd_data;

    spi_cmd_master #(.SETUP_CYC(SU), .TURN_CYC(TU), .GAP_CYC(GP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int prev_acc = 0;
    int prev_len = 0;
    logic [7:0] last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // One frame: the model lays out SS_n/MOSI/rd_valid per cycle from the command alone
    task automatic send(input logic [9:0] c, input logic [7:0] b, input bit b2b, input int abort_at);
        bit rd;
        int frame, caps, bound;
        logic em;
        rd = (c[9:8] == 2'b11);
        frame = SU + 10 + (rd ? TU + 8 : 0);
        caps = SU + 10 + TU;
        cmd_valid = 1'b1;
        cmd_data = c;
        bound = 0;
        while (!cmd_ready && bound < 100) begin
            @(posedge clk); #1;
            bound++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (b2b) chk("accept_spacing", 32'(cyc - 1 - prev_acc), 32'(prev_len + GP + 1));
        prev_acc = cyc - 1;
        prev_len = frame;
        cmd_data = 10'($urandom);
        for (int i = 0; i <= frame + GP; i++) begin
            MISO = (rd && i >= caps && i < caps + 8) ? b[7 - (i - caps)] : 1'($urandom);
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                last_rd = '0;
                chk("abort_ss_n", 32'(SS_n), 32'd1);
                chk("abort_mosi", 32'(MOSI), 32'd0);
                chk("abort_rd_valid", 32'(rd_valid), 32'd0);
                chk("abort_rd_data", 32'(rd_data), 32'h00);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_ready", 32'(cmd_ready), 32'd0);
                @(posedge clk); #1;
                chk("abort_rd_valid2", 32'(rd_valid), 32'd0);
                cmd_valid = 1'b0;
                rst = 1'b0;
                return;
            end
            if (rd && i == frame) last_rd = b;
            em = (i < SU) ? c[9] : (i < SU + 10) ? c[9 - (i - SU)] : 1'b0;
            chk("ss_n", 32'(SS_n), 32'(i >= frame));
            chk("mosi", 32'(MOSI), 32'(em));
            chk("rd_valid", 32'(rd_valid), 32'(rd && i == frame));
            chk("rd_data", 32'(rd_data), 32'(last_rd));
            chk("busy", 32'(busy), 32'(i < frame + GP));
            chk("cmd_ready", 32'(cmd_ready), 32'(i == frame + GP));
            if (i < frame + GP) begin
                @(posedge clk); #1;
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        cmd_valid = 1'b1;
        cmd_data = 10'h0FA;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_ss_n", 32'(SS_n), 32'd1);
            chk("rst_mosi", 32'(MOSI), 32'd0);
            chk("rst_rd_valid", 32'(rd_valid), 32'd0);
            chk("rst_rd_data", 32'(rd_data), 32'h00);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ready", 32'(cmd_ready), 32'd0);
        end
        rst = 1'b0;
        send(10'h0FA, 8'h00, 1'b0, -1);
        send(10'h1AF, 8'h00, 1'b1, -1);
        send(10'h2FA, 8'h00, 1'b1, -1);
        send(10'h333, 8'hAF, 1'b1, -1);
        send(10'h333, 8'h5C, 1'b1, -1);
        send(10'h333, 8'h96, 1'b1, SU + 10 + TU + 4);
        repeat (2) begin
            @(posedge clk); #1;
        end
        send(10'h333, 8'hAF, 1'b0, -1);
        for (int k = 0; k < 24; k++) begin
            bit gap;
            logic [9:0] c;
            gap = 1'($urandom);
            c = 10'($urandom);
            if (k % 3 == 0) c[9:8] = 2'b11;
            if (gap) repeat ($urandom_range(1, 3)) begin
                @(posedge clk); #1;
            end
            send(c, 8'($urandom), !gap, -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
